// File: rtl/weight_ctrl_pkg.sv
// Shared definitions for the weight tile scheduler.
// Holds the default BRAM address / tile index widths and the scheduler state
// encoding so the interface, the RTL and any debug tooling agree on them.
package weight_ctrl_pkg;

    localparam int ADDR_WIDTH_DEF = 11;
    localparam int TILE_W_DEF     = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOAD = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_RUN       = 3'd3,
        ST_WAIT_PE   = 3'd4,
        ST_DONE      = 3'd5
    } sched_state_e;

endpackage

// File: rtl/weight_tile_scheduler_if.sv
// Job-descriptor and transpose-counter bus of the weight tile scheduler.
//   cfg_*   : job descriptor handshake (valid/ready, base, tile length, count)
//   trans_* : start pulse, inclusive address range, and done pulse of the
//             transpose counter
// modport master : scheduler side (accepts jobs, drives the counter)
// modport slave  : environment side (job source + transpose counter)
interface weight_tile_scheduler_if
    import weight_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int TILE_W     = TILE_W_DEF
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [ADDR_WIDTH-1:0] cfg_base_addr;
    logic [ADDR_WIDTH:0]   cfg_tile_len;
    logic [TILE_W-1:0]     cfg_num_tiles;

    logic                  trans_start;
    logic [ADDR_WIDTH-1:0] trans_addr_start;
    logic [ADDR_WIDTH-1:0] trans_addr_end;
    logic                  trans_done;

    modport master (
        input  cfg_valid, cfg_base_addr, cfg_tile_len, cfg_num_tiles, trans_done,
        output cfg_ready, trans_start, trans_addr_start, trans_addr_end
    );

    modport slave (
        output cfg_valid, cfg_base_addr, cfg_tile_len, cfg_num_tiles, trans_done,
        input  cfg_ready, trans_start, trans_addr_start, trans_addr_end
    );
endinterface

// File: rtl/weight_tile_scheduler.sv
// Weight tile scheduler: sequences transpose-mode reads of the weight BRAM
// one tile at a time once the AXI loader reports the weights resident.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   bus (master)       : job descriptor in, transpose counter start/range out
//   weight_write_done  : loader pulse, sets the sticky "loaded" flag
//   pe_ready           : PE array can take the next tile
//   abort              : cancel the running job, back to IDLE
//   conv_grant         : convolution path may read the BRAM (low mid-tile)
//   tile_idx           : index of the current / last issued tile
//   busy, job_done     : status, one-cycle completion pulse
//   err_range          : sticky, last job would run past the BRAM end
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a job descriptor
// WAIT_LOAD | job accepted, waiting for the weights to be resident
// ISSUE     | one-cycle trans_start to the transpose counter
// RUN       | tile streaming, waiting for trans_done
// WAIT_PE   | between tiles, waiting for pe_ready
// DONE      | one-cycle job_done
module weight_tile_scheduler
    import weight_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int TILE_W     = TILE_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    weight_tile_scheduler_if.master bus,
    input  logic                    weight_write_done,
    input  logic                    pe_ready,
    input  logic                    abort,
    output logic                    conv_grant,
    output logic [TILE_W-1:0]       tile_idx,
    output logic                    busy,
    output logic                    job_done,
    output logic                    err_range
);

    localparam int SUM_W = ADDR_WIDTH + TILE_W + 1;
    localparam logic [SUM_W-1:0] DEPTH = SUM_W'(1) << ADDR_WIDTH;

    sched_state_e          state_q, state_d;
    logic                  loaded_q, loaded_d;
    logic                  trans_start_q, trans_start_d;
    logic                  busy_q, busy_d;
    logic                  job_done_q, job_done_d;
    logic                  err_range_q, err_range_d;
    logic [TILE_W-1:0]     tile_idx_q, tile_idx_d;
    logic [TILE_W-1:0]     num_tiles_q, num_tiles_d;
    logic [ADDR_WIDTH-1:0] tile_len_q, tile_len_d;
    logic [ADDR_WIDTH-1:0] addr_start_q, addr_start_d;
    logic [ADDR_WIDTH-1:0] addr_end_q, addr_end_d;
    logic [SUM_W-1:0]      job_end;

    // One past the last address the job would touch.
    assign job_end = SUM_W'(bus.cfg_base_addr)
                   + SUM_W'(bus.cfg_num_tiles) * SUM_W'(bus.cfg_tile_len);

    always_comb begin
        state_d      = state_q;
        err_range_d  = err_range_q;
        tile_idx_d   = tile_idx_q;
        num_tiles_d  = num_tiles_q;
        tile_len_d   = tile_len_q;
        addr_start_d = addr_start_q;
        addr_end_d   = addr_end_q;

        // A loader pulse wins over the clear on the job_done cycle.
        if (weight_write_done)
            loaded_d = 1'b1;
        else if (state_q == ST_DONE)
            loaded_d = 1'b0;
        else
            loaded_d = loaded_q;

        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cfg_valid) begin
                        num_tiles_d  = bus.cfg_num_tiles;
                        tile_len_d   = bus.cfg_tile_len[ADDR_WIDTH-1:0];
                        err_range_d  = 1'b0;
                        tile_idx_d   = '0;
                        addr_start_d = bus.cfg_base_addr;
                        addr_end_d   = bus.cfg_base_addr + bus.cfg_tile_len[ADDR_WIDTH-1:0]
                                     - ADDR_WIDTH'(1);
                        if (bus.cfg_num_tiles == '0 || bus.cfg_tile_len == '0) begin
                            state_d = ST_DONE;
                        end else if (job_end > DEPTH) begin
                            err_range_d = 1'b1;
                            state_d     = ST_DONE;
                        end else begin
                            state_d = ST_WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT_LOAD: begin
                    if (loaded_q || weight_write_done)
                        state_d = ST_ISSUE;
                end
                ST_ISSUE: state_d = ST_RUN;
                ST_RUN: begin
                    if (bus.trans_done) begin
                        if (tile_idx_q == num_tiles_q - TILE_W'(1)) begin
                            state_d = ST_DONE;
                        end else begin
                            tile_idx_d   = tile_idx_q + TILE_W'(1);
                            addr_start_d = addr_start_q + tile_len_q;
                            addr_end_d   = addr_end_q + tile_len_q;
                            state_d      = ST_WAIT_PE;
                        end
                    end
                end
                ST_WAIT_PE: begin
                    if (pe_ready)
                        state_d = ST_ISSUE;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        // Registered outputs are decoded from the next state so they line up
        // with the state they describe.
        trans_start_d = (state_d == ST_ISSUE);
        job_done_d    = (state_d == ST_DONE);
        busy_d        = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            loaded_q      <= 1'b0;
            trans_start_q <= 1'b0;
            busy_q        <= 1'b0;
            job_done_q    <= 1'b0;
            err_range_q   <= 1'b0;
            tile_idx_q    <= '0;
            num_tiles_q   <= '0;
            tile_len_q    <= '0;
            addr_start_q  <= '0;
            addr_end_q    <= '0;
        end else begin
            state_q       <= state_d;
            loaded_q      <= loaded_d;
            trans_start_q <= trans_start_d;
            busy_q        <= busy_d;
            job_done_q    <= job_done_d;
            err_range_q   <= err_range_d;
            tile_idx_q    <= tile_idx_d;
            num_tiles_q   <= num_tiles_d;
            tile_len_q    <= tile_len_d;
            addr_start_q  <= addr_start_d;
            addr_end_q    <= addr_end_d;
        end
    end

    assign bus.cfg_ready        = (state_q == ST_IDLE);
    assign bus.trans_start      = trans_start_q;
    assign bus.trans_addr_start = addr_start_q;
    assign bus.trans_addr_end   = addr_end_q;
    assign conv_grant           = !(state_q == ST_ISSUE || state_q == ST_RUN);
    assign tile_idx             = tile_idx_q;
    assign busy                 = busy_q;
    assign job_done             = job_done_q;
    assign err_range            = err_range_q;

endmodule

// File: tb/tb_weight_tile_scheduler.sv
// Self-checking bench for weight_tile_scheduler: directed jobs from the test
// plan followed by randomized jobs, checked against a job-level model.
module tb_weight_tile_scheduler;

    localparam int AW    = 11;
    localparam int TW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          weight_write_done = 1'b0;
    logic          pe_ready = 1'b0;
    logic          abort = 1'b0;
    logic          conv_grant;
    logic [TW-1:0] tile_idx;
    logic          busy;
    logic          job_done;
    logic          err_range;

    int n_chk  = 0;
    int n_pass = 0;
    bit model_loaded = 1'b0;

    weight_tile_scheduler_if #(.ADDR_WIDTH(AW), .TILE_W(TW)) bus ();

    weight_tile_scheduler #(.ADDR_WIDTH(AW), .TILE_W(TW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus),
        .weight_write_done (weight_write_done),
        .pe_ready          (pe_ready),
        .abort             (abort),
        .conv_grant        (conv_grant),
        .tile_idx          (tile_idx),
        .busy              (busy),
        .job_done          (job_done),
        .err_range         (err_range)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_wwd();
        weight_write_done = 1'b1;
        step();
        weight_write_done = 1'b0;
        model_loaded = 1'b1;
    endtask

    // pe_gap < 0 picks a random gap; abort_tile < 0 means no abort.
    task automatic run_job(input int base, input int len, input int n,
                           input int pe_gap, input int wl_gap, input int abort_tile);
        bit zero;
        bit err;
        int gap;
        int run;
        int exp_s;
        int exp_e;
        zero = (n == 0) || (len == 0);
        err  = !zero && (base + n * len > DEPTH);

        bus.cfg_valid     = 1'b1;
        bus.cfg_base_addr = AW'(base);
        bus.cfg_tile_len  = (AW+1)'(len);
        bus.cfg_num_tiles = TW'(n);
        chk("cfg_ready_idle", bus.cfg_ready, 1);
        step();
        bus.cfg_valid     = 1'b0;
        bus.cfg_base_addr = AW'($urandom);
        bus.cfg_tile_len  = (AW+1)'($urandom);
        bus.cfg_num_tiles = TW'($urandom);

        if (zero || err) begin
            chk("short_job_done", job_done, 1);
            chk("short_err_range", err_range, err);
            chk("short_no_start", bus.trans_start, 0);
            chk("short_busy", busy, 1);
            model_loaded = 1'b0;
            step();
            chk("short_done_clear", job_done, 0);
            chk("short_idle", busy, 0);
            chk("err_sticky", err_range, err);
            return;
        end

        chk("accept_err_clear", err_range, 0);
        chk("accept_busy", busy, 1);
        chk("accept_cfg_ready", bus.cfg_ready, 0);
        if (!model_loaded) begin
            repeat (wl_gap) begin
                chk("wait_load_hold", bus.trans_start, 0);
                chk("wait_load_grant", conv_grant, 1);
                step();
            end
            weight_write_done = 1'b1;
            step();
            weight_write_done = 1'b0;
            model_loaded = 1'b1;
        end else begin
            chk("preload_no_start", bus.trans_start, 0);
            step();
        end

        for (int i = 0; i < n; i++) begin
            exp_s = (base + i * len) % DEPTH;
            exp_e = (base + (i + 1) * len - 1) % DEPTH;
            chk("issue_start", bus.trans_start, 1);
            chk("issue_grant", conv_grant, 0);
            chk("issue_tile_idx", tile_idx, i);
            chk("issue_addr_start", bus.trans_addr_start, exp_s);
            chk("issue_addr_end", bus.trans_addr_end, exp_e);
            run = $urandom_range(1, 4);
            repeat (run) begin
                step();
                chk("run_no_start", bus.trans_start, 0);
                chk("run_grant", conv_grant, 0);
                chk("run_addr_start", bus.trans_addr_start, exp_s);
                chk("run_addr_end", bus.trans_addr_end, exp_e);
            end
            if (i == abort_tile) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_no_done", job_done, 0);
                chk("abort_grant", conv_grant, 1);
                chk("abort_cfg_ready", bus.cfg_ready, 1);
                bus.trans_done = 1'b1;
                step();
                bus.trans_done = 1'b0;
                chk("stray_done_busy", busy, 0);
                chk("stray_done_start", bus.trans_start, 0);
                chk("stray_done_job", job_done, 0);
                return;
            end
            bus.trans_done = 1'b1;
            step();
            bus.trans_done = 1'b0;
            if (i == n - 1) begin
                chk("job_done", job_done, 1);
                chk("done_grant", conv_grant, 1);
                model_loaded = 1'b0;
                step();
                chk("job_done_pulse", job_done, 0);
                chk("idle_busy", busy, 0);
                chk("idle_cfg_ready", bus.cfg_ready, 1);
            end else begin
                gap = (pe_gap < 0) ? int'($urandom_range(0, 4)) : pe_gap;
                chk("wait_pe_grant", conv_grant, 1);
                chk("wait_pe_tile_idx", tile_idx, i + 1);
                repeat (gap) begin
                    chk("wait_pe_hold", bus.trans_start, 0);
                    step();
                end
                pe_ready = 1'b1;
                step();
                pe_ready = 1'b0;
            end
        end
    endtask

    initial begin
        int n;
        int at;
        bus.cfg_valid     = 1'b0;
        bus.cfg_base_addr = '0;
        bus.cfg_tile_len  = '0;
        bus.cfg_num_tiles = '0;
        bus.trans_done    = 1'b0;

        step();
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        chk("rst_conv_grant", conv_grant, 1);
        chk("rst_trans_start", bus.trans_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_job_done", job_done, 0);
        chk("rst_err_range", err_range, 0);
        chk("rst_tile_idx", tile_idx, 0);
        chk("rst_addr_start", bus.trans_addr_start, 0);
        chk("rst_addr_end", bus.trans_addr_end, 0);
        rst_n = 1'b1;
        step();

        pulse_wwd();
        run_job(0, 128, 4, 0, 0, -1);
        run_job(0, 64, 3, 0, 20, -1);
        pulse_wwd();
        run_job(0, 128, 2, 10, 0, -1);
        pulse_wwd();
        run_job(1900, 64, 3, 0, 0, -1);
        pulse_wwd();
        run_job(0, 100, 3, -1, 0, 1);
        run_job(200, 50, 2, -1, 0, -1);
        pulse_wwd();
        run_job(5, 10, 0, -1, 0, -1);
        run_job(0, 16, 1, -1, 5, -1);
        pulse_wwd();
        run_job(0, 2048, 1, -1, 0, -1);
        pulse_wwd();
        run_job(2047, 1, 1, -1, 0, -1);
        run_job(2047, 2, 1, -1, 3, -1);
        run_job(7, 0, 3, -1, 0, -1);

        for (int j = 0; j < 30; j++) begin
            if ($urandom_range(0, 1) == 1)
                pulse_wwd();
            n  = $urandom_range(0, 6);
            at = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_job($urandom_range(0, 2047), $urandom_range(0, 150), n, -1,
                    $urandom_range(0, 6), at);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
